// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM state, Booth digit types and default width for the divider check
package div_pkg;

  localparam int DIV_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    M1,
    M2
  } booth_digit_t;

  // Radix-4 Booth recoding of one overlapping multiplier triplet {q[i+1], q[i], q[i-1]}
  function automatic booth_digit_t booth_decode(input logic [2:0] bits);
    booth_digit_t d;
    case (bits)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// rtl/booth_r4_enc.sv - Booth radix-4 recoder and partial-product mux
import div_pkg::*;

module booth_r4_enc #(
  parameter int WIDTH = DIV_W
) (
  input  logic [2:0]       bits,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] addend
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  booth_digit_t digit;

  always_comb begin
    digit  = booth_decode(bits);
    addend = '0;
    case (digit)
      P1:      addend = mcand;
      P2:      addend = mcand << 1;
      M1:      addend = ~mcand + ONE;
      M2:      addend = ~(mcand << 1) + ONE;
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/div_check_r4.sv
// rtl/div_check_r4.sv - recomposes quo*dvs+rem with a sequential Booth radix-4 MAC and compares to dvd
import div_pkg::*;

module div_check_r4 #(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o,
  output logic             match_o
);

  localparam int ITERS = WIDTH / 2;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_t           state, state_next;
  logic [WIDTH:0]   q_reg;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] exp_val;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] acc_next;
  logic             last_iter;

  booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
    .bits   (q_reg[2:0]),
    .mcand  (mcand),
    .addend (addend)
  );

  assign acc_next  = acc + addend;
  assign last_iter = (cnt == LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (vld_i) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready_o = (state == IDLE);
  assign done_o  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      q_reg   <= '0;
      mcand   <= '0;
      acc     <= '0;
      exp_val <= '0;
      cnt     <= '0;
      prod_o  <= '0;
      match_o <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (vld_i) begin
            q_reg   <= {quo_i, 1'b0};
            mcand   <= dvs_i;
            acc     <= rem_i;
            exp_val <= dvd_i;
            cnt     <= '0;
          end
        end
        CALC: begin
          acc   <= acc_next;
          mcand <= mcand << 2;
          q_reg <= {{2{q_reg[WIDTH]}}, q_reg[WIDTH:2]};
          cnt   <= cnt + CW'(1);
          // Result is latched on the final iteration so it is already valid while done_o is high
          if (last_iter) begin
            prod_o  <= acc_next;
            match_o <= (acc_next == exp_val);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
